// File: rtl/wb_stage.sv
// Writeback stage of the in-order RV32 core: retires one instruction per handshake,
// extracts load data, drives the register-file write port and counts retirements.
module wb_stage #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_wb_en,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wd,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_COMMIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TW-1:0]     r_tcnt;
    logic [4:0]        r_rd;
    logic              r_wb_en;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_we;
    logic [4:0]        r_rf_rd;
    logic [XLEN-1:0]   r_rf_wd;
    logic              r_load_err;
    logic [CNT_W-1:0]  r_retire_cnt;

    logic              w_accept;
    logic              w_timeout;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_COMMIT);
    assign w_accept   = in_valid && in_ready;
    assign rf_we      = (r_state == S_COMMIT) && r_we;
    assign rf_rd      = r_rf_rd;
    assign rf_wd      = r_rf_wd;
    assign load_err   = r_load_err;
    assign retire_cnt = r_retire_cnt;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            2'd3:    w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        // Undefined funct3 encodings fall through to a full-word load
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_accept)
                    w_next = in_is_load ? S_LOAD_WAIT : S_COMMIT;
                else
                    w_next = S_IDLE;
            end
            S_LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    w_next = S_COMMIT;
                end else if (r_tcnt == TW'(LOAD_TIMEOUT - 1)) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tcnt       <= '0;
            r_rd         <= '0;
            r_wb_en      <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_we         <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_wd      <= '0;
            r_load_err   <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_load_err <= w_timeout;
            // Retire count advances on entry to COMMIT so it is visible during the commit cycle
            if (w_accept) begin
                r_rd      <= in_rd;
                r_wb_en   <= in_wb_en;
                r_funct3  <= in_funct3;
                r_addr_lo <= in_addr_lo;
                r_tcnt    <= '0;
                if (!in_is_load) begin
                    r_rf_rd      <= in_rd;
                    r_rf_wd      <= in_result;
                    r_we         <= in_wb_en && (in_rd != 5'd0);
                    r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                end
            end else if (r_state == S_LOAD_WAIT) begin
                if (dmem_rvalid) begin
                    r_rf_rd      <= r_rd;
                    r_rf_wd      <= w_load_data;
                    r_we         <= r_wb_en && (r_rd != 5'd0);
                    r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

endmodule
